// File: rtl/ram_port_arb.sv
// Round-robin arbiter that shares one single-port data RAM between IFU fetches and LSU
// loads/stores, running one ISSUE/WAIT/RESP transaction at a time with registered RAM strobes.
module ram_port_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_LAT    = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ifu_req_valid,
  output logic                      o_ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]     i_ifu_req_addr,
  output logic                      o_ifu_rsp_valid,
  input  logic                      i_ifu_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_ifu_rsp_data,
  input  logic                      i_lsu_req_valid,
  output logic                      o_lsu_req_ready,
  input  logic                      i_lsu_req_wr_en,
  input  logic [ADDR_WIDTH-1:0]     i_lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]     i_lsu_req_wr_data,
  input  logic [DATA_WIDTH/8-1:0]   i_lsu_req_wr_mask,
  output logic                      o_lsu_rsp_valid,
  input  logic                      i_lsu_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_lsu_rsp_data,
  output logic                      o_ram_en,
  output logic                      o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0]     o_ram_addr,
  output logic [DATA_WIDTH-1:0]     o_ram_wr_data,
  output logic [DATA_WIDTH/8-1:0]   o_ram_wr_mask,
  input  logic [DATA_WIDTH-1:0]     i_ram_rd_data,
  output logic                      o_busy
);

  localparam int unsigned CNT_WIDTH = $clog2(RAM_LAT + 1);

  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
    $error("ram_port_arb: RAM_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state;
  logic                 last_gnt;   // 0 = IFU, 1 = LSU
  logic                 owner_lsu;
  logic                 req_store;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 gnt_ifu;
  logic                 gnt_lsu;
  logic                 rsp_done;

  // Round-robin grant: on contention, the side not served last wins
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (i_ifu_req_valid && i_lsu_req_valid) begin
      if (last_gnt) gnt_ifu = 1'b1;
      else          gnt_lsu = 1'b1;
    end else if (i_ifu_req_valid) begin
      gnt_ifu = 1'b1;
    end else if (i_lsu_req_valid) begin
      gnt_lsu = 1'b1;
    end
  end

  assign o_ifu_req_ready = (state == S_IDLE) && gnt_ifu;
  assign o_lsu_req_ready = (state == S_IDLE) && gnt_lsu;
  assign rsp_done = owner_lsu ? (o_lsu_rsp_valid && i_lsu_rsp_ready)
                              : (o_ifu_rsp_valid && i_ifu_rsp_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      last_gnt        <= 1'b0;
      owner_lsu       <= 1'b0;
      req_store       <= 1'b0;
      wait_cnt        <= '0;
      o_ram_en        <= 1'b0;
      o_ram_wr_en     <= 1'b0;
      o_ram_addr      <= '0;
      o_ram_wr_data   <= '0;
      o_ram_wr_mask   <= '0;
      o_ifu_rsp_valid <= 1'b0;
      o_ifu_rsp_data  <= '0;
      o_lsu_rsp_valid <= 1'b0;
      o_lsu_rsp_data  <= '0;
      o_busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (o_ifu_req_ready || o_lsu_req_ready) begin
            state     <= S_ISSUE;
            o_busy    <= 1'b1;
            wait_cnt  <= '0;
            o_ram_en  <= 1'b1;
            owner_lsu <= o_lsu_req_ready;
            last_gnt  <= o_lsu_req_ready;
            if (o_lsu_req_ready) begin
              req_store     <= i_lsu_req_wr_en;
              o_ram_addr    <= i_lsu_req_addr;
              o_ram_wr_en   <= i_lsu_req_wr_en;
              o_ram_wr_data <= i_lsu_req_wr_en ? i_lsu_req_wr_data : '0;
              o_ram_wr_mask <= i_lsu_req_wr_en ? i_lsu_req_wr_mask : '0;
            end else begin
              req_store     <= 1'b0;
              o_ram_addr    <= i_ifu_req_addr;
              o_ram_wr_en   <= 1'b0;
              o_ram_wr_data <= '0;
              o_ram_wr_mask <= '0;
            end
          end
        end
        S_ISSUE: begin
          state         <= S_WAIT;
          o_ram_en      <= 1'b0;
          o_ram_wr_en   <= 1'b0;
          o_ram_addr    <= '0;
          o_ram_wr_data <= '0;
          o_ram_wr_mask <= '0;
        end
        S_WAIT: begin
          // Read data is valid RAM_LAT cycles after the ISSUE cycle
          if (wait_cnt == CNT_WIDTH'(RAM_LAT - 1)) begin
            state <= S_RESP;
            if (owner_lsu) begin
              o_lsu_rsp_valid <= 1'b1;
              o_lsu_rsp_data  <= req_store ? '0 : i_ram_rd_data;
            end else begin
              o_ifu_rsp_valid <= 1'b1;
              o_ifu_rsp_data  <= i_ram_rd_data;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end
        S_RESP: begin
          if (rsp_done) begin
            state           <= S_IDLE;
            o_busy          <= 1'b0;
            o_ifu_rsp_valid <= 1'b0;
            o_ifu_rsp_data  <= '0;
            o_lsu_rsp_valid <= 1'b0;
            o_lsu_rsp_data  <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
